rom_port_arbiter: RTL

- Shares the single combinational instruction ROM read port between instruction fetch (IF) and the load unit (LD).
- Performs one ROM access per cycle and arbitrates round-robin on contention.
- Always presents a word-aligned address to the ROM, then extracts and sign/zero-extends byte lanes for loads.
- Returns registered responses with valid/ready backpressure and an error flag. Sits between the core front end / LSU and the ROM.

---
 rtl/rom_ctrl_pkg.sv | 18 +
 rtl/load_align.sv | 43 ++++
 rtl/rom_port_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/rom_ctrl_pkg.sv
// Shared constants for the ROM port arbiter: load funct3 encodings,
// requester port indices and the default ROM address width.
package rom_ctrl_pkg;

  localparam int ADDR_W_DEFAULT = 12;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LD = 1'b1
  } port_e;

endpackage

// File: rtl/load_align.sv
// Combinational byte/halfword lane extraction and sign/zero extension for
// RV32I loads; flags misaligned accesses and unsupported funct3 values.
module load_align
  import rom_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      lane,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            err
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = word[{lane, 3'b000} +: 8];
    half_val = lane[1] ? word[31:16] : word[15:0];
    data     = '0;
    err      = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_val[7]}}, byte_val};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_val};
      F3_LH: begin
        err  = lane[0];
        data = {{(XLEN-16){half_val[15]}}, half_val};
      end
      F3_LHU: begin
        err  = lane[0];
        data = {{(XLEN-16){1'b0}}, half_val};
      end
      F3_LW: begin
        err  = (lane != 2'b00);
        data = word;
      end
      default: err = 1'b1;
    endcase
    if (err) data = '0;
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Round-robin sharing of one combinational ROM read port between instruction
// fetch and the load unit, with registered, backpressured responses.
module rom_port_arbiter
  import rom_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int XLEN   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [XLEN-1:0] if_req_addr,
  input  logic            if_flush,
  output logic            if_rsp_valid,
  input  logic            if_rsp_ready,
  output logic [XLEN-1:0] if_rsp_data,
  output logic            if_rsp_err,
  input  logic            ld_req_valid,
  output logic            ld_req_ready,
  input  logic [XLEN-1:0] ld_req_addr,
  input  logic [2:0]      ld_req_funct3,
  output logic            ld_rsp_valid,
  input  logic            ld_rsp_ready,
  output logic [XLEN-1:0] ld_rsp_data,
  output logic            ld_rsp_err,
  output logic [XLEN-1:0] rom_addr,
  input  logic [XLEN-1:0] rom_data
);

  // Handshake: a request transfers when req_valid && req_ready on a rising
  // edge; a response transfers when rsp_valid && rsp_ready. rsp_valid, once
  // set, holds data/err stable until consumed (or flushed, for IF).
  port_e           last_grant;
  logic            if_slot_free, ld_slot_free;
  logic            if_elig, ld_elig;
  logic            grant_if, grant_ld;
  logic            if_err_next;
  logic            ld_range_err, ld_align_err, ld_err_next;
  logic [XLEN-1:0] if_data_next, ld_data_next, ld_align_data;

  // A slot being consumed this cycle may be refilled in the same cycle.
  assign if_slot_free = !if_rsp_valid || if_rsp_ready;
  assign ld_slot_free = !ld_rsp_valid || ld_rsp_ready;
  assign if_elig      = if_req_valid && if_slot_free && !if_flush;
  assign ld_elig      = ld_req_valid && ld_slot_free;

  assign grant_if     = if_elig && (!ld_elig || last_grant == PORT_LD);
  assign grant_ld     = ld_elig && !grant_if;
  assign if_req_ready = grant_if;
  assign ld_req_ready = grant_ld;

  always_comb begin
    rom_addr = '0;
    if (grant_if)      rom_addr = {if_req_addr[XLEN-1:2], 2'b00};
    else if (grant_ld) rom_addr = {ld_req_addr[XLEN-1:2], 2'b00};
  end

  assign if_err_next  = (if_req_addr[1:0] != 2'b00) || (|if_req_addr[XLEN-1:ADDR_W]);
  assign if_data_next = if_err_next ? '0 : rom_data;

  load_align #(.XLEN(XLEN)) u_load_align (
    .word   (rom_data),
    .lane   (ld_req_addr[1:0]),
    .funct3 (ld_req_funct3),
    .data   (ld_align_data),
    .err    (ld_align_err)
  );

  assign ld_range_err = |ld_req_addr[XLEN-1:ADDR_W];
  assign ld_err_next  = ld_align_err || ld_range_err;
  assign ld_data_next = ld_err_next ? '0 : ld_align_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant   <= PORT_LD;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      if_rsp_err   <= 1'b0;
      ld_rsp_valid <= 1'b0;
      ld_rsp_data  <= '0;
      ld_rsp_err   <= 1'b0;
    end else begin
      if (grant_if)      last_grant <= PORT_IF;
      else if (grant_ld) last_grant <= PORT_LD;

      // Flush drops any unconsumed fetch; grant_if is already low here.
      if (if_flush) begin
        if_rsp_valid <= 1'b0;
      end else if (grant_if) begin
        if_rsp_valid <= 1'b1;
        if_rsp_data  <= if_data_next;
        if_rsp_err   <= if_err_next;
      end else if (if_rsp_ready) begin
        if_rsp_valid <= 1'b0;
      end

      if (grant_ld) begin
        ld_rsp_valid <= 1'b1;
        ld_rsp_data  <= ld_data_next;
        ld_rsp_err   <= ld_err_next;
      end else if (ld_rsp_ready) begin
        ld_rsp_valid <= 1'b0;
      end
    end
  end

endmodule
